// File: rtl/bf16_simd_cvt_minmax.sv
// LANES-wide BF16 convert / min-max engine with valid/ready pipeline and sticky FP flags.
// Define BF16CVT_MINMAX_EN to build the MAX/MIN comparator; otherwise opcodes 0010/0011 are illegal.

module bf16_lane (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic [4:0]  flags
);
    logic [15:0] hi, rounded;
    logic        rnd, stk, inexact, nan32;

    assign hi      = a[31:16];
    assign rnd     = a[15];
    assign stk     = |a[14:0];
    assign inexact = rnd | stk;
    assign rounded = hi + {15'd0, rnd & (stk | a[16])};
    assign nan32   = (&a[30:23]) & (|a[22:0]);

`ifdef BF16CVT_MINMAX_EN
    logic [15:0] a16, b16, key_a, key_b, pick_max, pick_min;
    logic        nan_a, nan_b, snan_a, snan_b, a_gt;
    logic        unused_b;

    assign unused_b = ^b[31:16];
    assign a16      = a[15:0];
    assign b16      = b[15:0];
    assign nan_a    = (&a16[14:7]) & (|a16[6:0]);
    assign nan_b    = (&b16[14:7]) & (|b16[6:0]);
    assign snan_a   = nan_a & ~a16[6];
    assign snan_b   = nan_b & ~b16[6];
    // Sign-magnitude to unsigned ordering key; places -0 just below +0.
    assign key_a    = a16[15] ? ~a16 : (a16 | 16'h8000);
    assign key_b    = b16[15] ? ~b16 : (b16 | 16'h8000);
    assign a_gt     = key_a > key_b;

    always_comb begin
        pick_max = a_gt ? a16 : b16;
        pick_min = a_gt ? b16 : a16;
        if (nan_a && nan_b) begin
            pick_max = 16'h7FC0;
            pick_min = 16'h7FC0;
        end else if (nan_a) begin
            pick_max = b16;
            pick_min = b16;
        end else if (nan_b) begin
            pick_max = a16;
            pick_min = a16;
        end
    end
`else
    logic unused_b;
    assign unused_b = ^b;
`endif

    always_comb begin
        res   = '0;
        flags = '0;
        case (op)
            4'h0: begin
                if ((&a[14:7]) && (|a[6:0]) && !a[6]) begin
                    res      = 32'h7FC0_0000;
                    flags[4] = 1'b1;
                end else begin
                    res = {a[15:0], 16'h0};
                end
            end
            4'h1: begin
                if (nan32) begin
                    res      = 32'h0000_7FC0;
                    flags[4] = ~a[22];
                end else begin
                    res      = {16'h0, rounded};
                    flags[0] = inexact;
                    // Only a rounding increment can reach exp=0xFF from a finite input.
                    flags[2] = (&rounded[14:7]) & inexact;
                    flags[1] = (rounded[14:7] == 8'h00) & inexact;
                end
            end
`ifdef BF16CVT_MINMAX_EN
            4'h2: begin
                res      = {16'h0, pick_max};
                flags[4] = snan_a | snan_b;
            end
            4'h3: begin
                res      = {16'h0, pick_min};
                flags[4] = snan_a | snan_b;
            end
`endif
            default: ;
        endcase
    end
endmodule

module bf16_simd_cvt_minmax #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [32*LANES-1:0]   in_a,
    input  logic [32*LANES-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_result,
    output logic [TAG_W-1:0]      out_tag,
    output logic [4:0]            out_flags,
    input  logic                  clr_flags,
    output logic [31:0]           fpcsr
);
    localparam int W = 32 * LANES;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     result;
        logic [4:0]       flags;
        logic             ill;
    } beat_t;

    logic [LANES-1:0][31:0] lane_res;
    logic [LANES-1:0][4:0]  lane_flg;
    logic                   legal, advance, accept, fire;
    beat_t                  in_beat;
    beat_t                  stg [1:PIPE_STAGES];
    logic [PIPE_STAGES:1]   vld_pipe;
    logic [4:0]             flg_sticky;
    logic                   ill_sticky;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            bf16_lane u_lane (
                .op    (in_op),
                .a     (in_a[32*gi +: 32]),
                .b     (in_b[32*gi +: 32]),
                .res   (lane_res[gi]),
                .flags (lane_flg[gi])
            );
        end
    endgenerate

`ifdef BF16CVT_MINMAX_EN
    assign legal = (in_op[3:2] == 2'b00);
`else
    assign legal = (in_op[3:1] == 3'b000);
`endif

    // Lanes already return zero for opcodes they do not implement.
    always_comb begin
        in_beat.tag    = in_tag;
        in_beat.result = lane_res;
        in_beat.ill    = ~legal;
        in_beat.flags  = '0;
        for (int i = 0; i < LANES; i++) in_beat.flags = in_beat.flags | lane_flg[i];
    end

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    assign fire     = out_valid & out_ready;

    // Whole pipe moves or holds as one; bubbles are kept so latency stays fixed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 1; i <= PIPE_STAGES; i++) stg[i] <= '0;
        end else if (advance) begin
            vld_pipe[1] <= accept;
            stg[1]      <= in_beat;
            for (int i = 2; i <= PIPE_STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                stg[i]      <= stg[i-1];
            end
        end
    end

    assign out_valid  = vld_pipe[PIPE_STAGES];
    assign out_result = stg[PIPE_STAGES].result;
    assign out_tag    = stg[PIPE_STAGES].tag;
    assign out_flags  = stg[PIPE_STAGES].flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flg_sticky <= '0;
            ill_sticky <= 1'b0;
        end else if (clr_flags) begin
            flg_sticky <= '0;
            ill_sticky <= 1'b0;
        end else if (fire) begin
            flg_sticky <= flg_sticky | out_flags;
            ill_sticky <= ill_sticky | stg[PIPE_STAGES].ill;
        end
    end

    assign fpcsr = {23'd0, ill_sticky, 3'd0, flg_sticky};
endmodule

// File: tb/tb_bf16_simd_cvt_minmax.sv
// Scoreboard bench for bf16_simd_cvt_minmax: directed vectors, stall/stream, illegal op and reset.
module tb_bf16_simd_cvt_minmax;
    localparam int LANES = 4;
    localparam int PS    = 2;
    localparam int TW    = 4;
    localparam int W     = 32 * LANES;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic [4:0]    out_flags;
    logic          clr_flags = 1'b0;
    logic [31:0]   fpcsr;

    always #5 clk = ~clk;

    bf16_simd_cvt_minmax #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags), .clr_flags(clr_flags), .fpcsr(fpcsr)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic [4:0]    flags;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   popped = 0;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endfunction

    // Monitor: pops on every handshake and checks output stability across stalls.
    logic          stall_seen = 1'b0;
    logic [W-1:0]  st_res;
    logic [TW-1:0] st_tag;
    logic [4:0]    st_flg;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_result", out_result, st_res);
                chk("stall_tag", out_tag, st_tag);
                chk("stall_flags", out_flags, st_flg);
            end
            stall_seen = 1'b0;
            if (out_valid && !out_ready) begin
                stall_seen = 1'b1;
                st_res = out_result;
                st_tag = out_tag;
                st_flg = out_flags;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got tag %h expected no beat", out_tag);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    chk("out_tag", out_tag, e.tag);
                    chk("out_result", out_result, e.res);
                    chk("out_flags", out_flags, e.flags);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [TW-1:0] tag,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic [4:0] ef);
        exp_t e;
        int   t;
        t = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_tag   = tag;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 (tag %h)", tag);
        end else begin
            @(posedge clk);
            e.tag = tag; e.res = er; e.flags = ef;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        cyc(1);
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n, vcount, base;
        logic [15:0] v;
        logic [W-1:0] sa, se;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_fpcsr", fpcsr, 0);
        reset = 1'b0;
        cyc(1);

        // FP32->BF16 rounding, overflow and sNaN
        send(4'h1, 4'd1,
             {32'h7FA00000, 32'h7F7FFFFF, 32'h3F818000, 32'h3F808000}, '0,
             {32'h00007FC0, 32'h00007F80, 32'h00003F82, 32'h00003F80}, 5'b10101);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("latency", n, PS);
        drain();
        chk("fpcsr_cvt32", fpcsr, 32'h15);
        clear_flags();
        chk("fpcsr_clr1", fpcsr, 0);

        // BF16->FP32
        send(4'h0, 4'd2,
             {32'h00007FC1, 32'h0000FF80, 32'h00007F81, 32'h00004049}, '0,
             {32'h7FC10000, 32'hFF800000, 32'h7FC00000, 32'h40490000}, 5'b10000);
        send(4'h0, 4'd3, {96'h0, 32'h00004049}, '0, {96'h0, 32'h40490000}, 5'b00000);
        drain();
        chk("fpcsr_cvt16", fpcsr, 32'h10);
        clear_flags();

        // Underflow / exact infinity / sticky-only inexact
        send(4'h1, 4'd4,
             {32'h3F7FFFFF, 32'h7F800000, 32'h80000001, 32'h00018000}, '0,
             {32'h00003F80, 32'h00007F80, 32'h00008000, 32'h00000002}, 5'b00011);
        drain();
        chk("fpcsr_uf", fpcsr, 32'h03);
        clear_flags();

        // MAX / MIN
`ifdef BF16CVT_MINMAX_EN
        send(4'h2, 4'd5,
             {32'h00007FC0, 32'h00000000, 32'h00007FC0, 32'h00003F80},
             {32'h00007FC1, 32'h00008000, 32'h00004000, 32'h0000BF80},
             {32'h00007FC0, 32'h00000000, 32'h00004000, 32'h00003F80}, 5'b00000);
        send(4'h2, 4'd6, {96'h0, 32'h00007F81}, {96'h0, 32'h00004000},
             {96'h0, 32'h00004000}, 5'b10000);
        send(4'h3, 4'd7,
             {32'h00004000, 32'h0000C000, 32'h00003F80, 32'h00000000},
             {32'h00007FC0, 32'h0000BF80, 32'h0000BF80, 32'h00008000},
             {32'h00004000, 32'h0000C000, 32'h0000BF80, 32'h00008000}, 5'b00000);
        drain();
        chk("fpcsr_minmax", fpcsr, 32'h10);
`else
        send(4'h2, 4'd5,
             {32'h00007FC0, 32'h00000000, 32'h00007FC0, 32'h00003F80},
             {32'h00007FC1, 32'h00008000, 32'h00004000, 32'h0000BF80}, '0, 5'b00000);
        send(4'h3, 4'd7, {96'h0, 32'h00007F81}, {96'h0, 32'h00004000}, '0, 5'b00000);
        drain();
        chk("fpcsr_minmax_ill", fpcsr, 32'h100);
`endif
        clear_flags();

        // Streaming with a 3-cycle output stall
        base = popped;
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    sa = '0;
                    se = '0;
                    for (int i = 0; i < LANES; i++) begin
                        v = 16'h4000 + 16'(t * 16 + i);
                        sa[32*i +: 32] = {16'h0, v};
                        se[32*i +: 32] = {v, 16'h0};
                    end
                    send(4'h0, TW'(t), sa, '0, se, 5'b00000);
                end
            end
            begin
                cyc(4);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("in_ready_full", in_ready, 0);
                chk("out_valid_full", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", popped - base, 8);

        // Illegal opcode, then clear
        send(4'hF, 4'd9, {W{1'b1}}, {W{1'b1}}, '0, 5'b00000);
        drain();
        chk("fpcsr_ill", fpcsr, 32'h100);
        clear_flags();
        chk("fpcsr_clr_ill", fpcsr, 0);

        // Completion in the same cycle as clr_flags
        out_ready = 1'b0;
        send(4'h0, 4'd10, {96'h0, 32'h00007F81}, '0, {96'h0, 32'h7FC00000}, 5'b10000);
        n = 0;
        while (!out_valid && n < 20) begin
            cyc(1);
            n++;
        end
        chk("held_valid", out_valid, 1);
        out_ready = 1'b1;
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        chk("clr_wins_pending", sb.size(), 0);
        chk("clr_wins_fpcsr", fpcsr, 0);
        cyc(1);
        chk("clr_wins_fpcsr2", fpcsr, 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(4'h0, 4'd11, {96'h0, 32'h00003F80}, '0, {96'h0, 32'h3F800000}, 5'b00000);
        send(4'h0, 4'd12, {96'h0, 32'h00004000}, '0, {96'h0, 32'h40000000}, 5'b00000);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        sb.delete();
        cyc(2);
        reset = 1'b0;
        out_ready = 1'b1;
        vcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("no_stale_beat", vcount, 0);
        chk("final_pending", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bf16_simd_cvt_minmax.md
# bf16_simd_cvt_minmax

Parametrised, pipelined BF16 conversion and min/max engine with a valid/ready handshake. It processes LANES independent 32-bit lanes per beat and accumulates sticky FP flags. It is the next-generation conversion/min-max execution unit behind the accelerator's opcode decoder. Results leave in order with a pass-through tag, so the decoder can have several operations in flight.

## Interface
- LANES, 4: number of 32-bit lanes per beat (≥1).
- PIPE_STAGES, 2: pipeline depth in register stages (≥1).
- TAG_W, 4: width of the opaque tag carried with each beat.

Ports:
- clk  in  1  clock; reset: reset, asynchronous, active-high; clock clk.
- reset  in  1  async active-high reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_op  in  4  opcode: 0000 BF16→FP32, 0001 FP32→BF16, 0010 MAX, 0011 MIN.
- in_tag  in  TAG_W  tag.
- in_a  in  32*LANES  operand A; lane i is bits [32i+31:32i].
- in_b  in  32*LANES  operand B (min/max only).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts.
- out_result  out  32*LANES  per-lane result.
- out_tag  out  TAG_W  tag of this beat.
- out_flags  out  5  OR of this beat's lane flags {NV,DZ,OF,UF,NX}.
- clr_flags  in  1  synchronous clear of the sticky flags.
- fpcsr  out  32  [4:0] sticky {NV,DZ,OF,UF,NX}; [8] sticky illegal-op; all other bits 0.

## Operation
- BF16→FP32: result = {a[15:0],16'h0}. For an sNaN input (exp all ones, mant≠0, bit6=0): result 0x7FC00000 and NV.
- FP32→BF16, round-to-nearest-even: hi = a[31:16], R = a[15], S = |a[14:0], L = a[16]; increment hi if R & (S|L).
  - NaN input: 0x7FC0, plus NV if sNaN (a[22]=0).
  - Finite input with R|S: NX.
  - Finite input that rounds to exp=0xFF: OF|NX; the result is the rounded value (±inf).
  - Result exp=0 and inexact: UF.
  - Result is zero-extended to 32 bits.
- MAX/MIN on a[15:0], b[15:0]:
  - −0 < +0.
  - One NaN: return the other operand.
  - Both NaN: return 0x7FC0.
  - Any sNaN operand: NV.
  - Result is zero-extended.
- Any other opcode: all lanes return 0; set fpcsr[8]. The beat still flows and completes normally.
- DZ is never set.
- Sticky update: when a beat completes (out_valid & out_ready), fpcsr[4:0] |= out_flags.
  - clr_flags in the same cycle wins: the sticky bits clear and the new flags are dropped.
  - clr_flags also clears bit 8.

## Timing
- Reset values: in_ready=1, out_valid=0, out_result=0, out_tag=0, out_flags=0, fpcsr=0. All pipeline valid bits clear.
- Latency: exactly PIPE_STAGES cycles from the accepting edge to out_valid when not stalled. Throughput is 1 beat/cycle.
- Handshake and stalls:
  - Pipeline advance = !out_valid | out_ready; in_ready = advance. This is combinational from out_ready.
  - While stalled (out_valid & !out_ready), every stage holds and out_result/out_tag/out_flags stay stable.
  - Bubbles do not collapse while stalled.
- Simultaneous accept and output on one edge: both happen; occupancy is unchanged.
- Occupancy is at most PIPE_STAGES beats. There is no internal buffering beyond the stages.
- Reset mid-operation: all in-flight beats are discarded and no result is emitted for them.
- fpcsr updates on the edge after completion. clr_flags takes effect on the next edge.

## Configuration
- BF16CVT_MINMAX_EN defined: MAX/MIN are supported as described.
- Undefined:
  - Opcodes 0010/0011 are treated as illegal (zero result, fpcsr[8]).
  - The comparator logic is not synthesised.
  - Conversion behaviour and timing are unchanged.

## Test plan
- LANES=4, PIPE_STAGES=2, op 0001, lanes {0x3F808000, 0x3F818000, 0x7F7FFFFF, 0x7FA00000} → out_valid 2 cycles later:
  - lane results {0x3F80, 0x3F82, 0x7F80, 0x7FC0};
  - out_flags = NV|OF|NX;
  - fpcsr[4:0] = 5'b10101 after the handshake.
- Op 0000, lane 0x00004049 → 0x40490000, no flags; lane 0x00007F81 → 0x7FC00000, NV.
- Op 0010/0011:
  - MAX(0x3F80, 0xBF80) = 0x3F80;
  - MIN(0x0000, 0x8000) = 0x8000;
  - MAX(0x7FC0, 0x4000) = 0x4000 with no NV;
  - MAX(0x7F81, 0x4000) = 0x4000 with NV.
- Back-to-back stream of 8 beats (tags 0..7) with out_ready held low for 3 cycles mid-stream:
  - tags emerge in order, no beat is lost or duplicated;
  - in_ready falls when the pipe is full;
  - outputs are stable while stalled.
- Op 1111 → all lanes 0 and fpcsr[8]=1. Next cycle assert clr_flags → fpcsr=0; completing a flagged beat in the same cycle as clr_flags leaves fpcsr=0.
- Assert reset with 2 beats in flight → out_valid=0 and in_ready=1 immediately, and no stale beat appears after release.
